perf_tcp_axil_cmd_master: RTL
=============================

Name: perf_tcp_axil_cmd_master

Overview:
AXI4-Lite initiator that turns single-beat commands from an in-fabric requester into AXI4-Lite transactions toward a slave register file. One transaction in flight at a time. Returns read data, or write completion plus response code, on a response stream. A watchdog flags a slave that never answers. Used to drive the TCP perf control/status register maps from on-chip sequencers and bring-up logic instead of the host.

Parameters:
ADDR_BITS, 64, AXI4-Lite address width.
DATA_BITS, 64, AXI4-Lite data width; must be 32 or 64.
TIMEOUT_CYCLES, 1024, cycles without slave progress before timeout; must be ≥2; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when high together with cmd_valid.
cmd_wr  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_BITS  byte address, passed unmodified.
cmd_wdata  in  DATA_BITS  write data; ignored for reads.
cmd_wstrb  in  DATA_BITS/8  write strobes; ignored for reads.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer ready.
rsp_wr  out  1  echo of cmd_wr.
rsp_rdata  out  DATA_BITS  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP as received.
rsp_timeout  out  1  watchdog expired (terminal).
busy  out  1  high in any state other than IDLE.
axi_ctrl  AXI4L.m  -  AXI4-Lite master port.

Behaviour:
- Reset (asynchronous, aresetn low): all outputs 0; all AXI valid/ready outputs 0; state IDLE. Reset mid-transaction aborts it immediately, with no response issued.
- cmd_ready = 1 only in IDLE; a handshake captures all cmd_* fields into registers.
- States:
  - IDLE.
  - WR_REQ: awvalid and wvalid asserted together on the cycle after acceptance. Each valid drops independently after its own handshake. Either order, or both in the same cycle, is legal. Leave when both handshakes have completed.
  - WR_RESP: bready = 1; on bvalid, capture bresp and go to RSP.
  - RD_REQ: arvalid = 1; on arready, go to RD_RESP.
  - RD_RESP: rready = 1; on rvalid, capture rdata and rresp and go to RSP.
  - RSP: rsp_valid = 1; on rsp_ready, go to IDLE.
  - HUNG: terminal.
- awaddr, araddr, wdata and wstrb come from the captured registers and stay stable while the matching valid is high. awprot and arprot are 0.
- A valid, once asserted, never drops before its handshake.
- Minimum latency with an always-ready slave that responds in the cycle after the request: cmd handshake at T, AW/W (or AR) valid at T+1, B/R at T+2, rsp_valid at T+3. A new cmd is accepted at the earliest on the cycle after the rsp handshake.
- rsp_* fields are held constant while rsp_valid is high and rsp_ready is low.
- Watchdog:
  - Counts in WR_REQ, WR_RESP, RD_REQ and RD_RESP; cleared on entry to each of these states and on every AXI handshake.
  - When it reaches TIMEOUT_CYCLES: rsp_valid = 1, rsp_timeout = 1, rsp_resp = 2'b10, and state moves to HUNG.
  - Pending AXI valids stay asserted (AXI rules forbid withdrawing them). bready/rready stay high so a late response is absorbed and discarded.
  - HUNG holds rsp_valid until rsp_ready, then keeps rsp_valid low. cmd_ready stays 0 until reset.
- Error responses (SLVERR/DECERR) are reported unchanged in rsp_resp with rsp_timeout = 0. They are not retried.
- A B or R handshake arriving with no request outstanding cannot occur, because bready/rready are 0 outside WR_RESP/RD_RESP/HUNG.

Test Plan:
- Write addr 0x8, wdata 0x1F90, wstrb 0xFF; slave ready immediately → AW and W valid together at T+1; rsp at T+3 with rsp_wr = 1, rsp_resp = 0, rsp_rdata = 0.
- Write where the slave asserts wready 3 cycles before awready → wvalid drops after its handshake; awvalid holds with awaddr stable; exactly one B accepted; one response issued.
- Read addr 0x28, slave returns 0x00000005 after 4 wait cycles on arready and 2 on rvalid → rsp_rdata = 5, rsp_resp = 0; arvalid stable throughout.
- Read returning rresp = 2'b11 while rsp_ready is held low for 5 cycles → rsp fields stable, rsp_resp = 3; cmd_ready low until the rsp handshake.
- TIMEOUT_CYCLES = 16, slave never asserts arready → timeout response exactly 16 cycles after arvalid rises (rsp_timeout = 1, resp = 2); further cmds are not accepted; busy = 1.
- aresetn pulsed low mid-WR_RESP → awvalid, wvalid, bready, rsp_valid and busy go to 0 without waiting for a clock edge; the next write after reset completes normally.

Source files
------------

// File: rtl/perf_tcp_axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave register file.
interface perf_tcp_axil_cmd_master_if #(
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 64
) ();
    logic                     awvalid;
    logic                     awready;
    logic [ADDR_BITS-1:0]     awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [DATA_BITS-1:0]     wdata;
    logic [DATA_BITS/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDR_BITS-1:0]     araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [DATA_BITS-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/perf_tcp_axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction
// out, one response back. A watchdog parks the block in HUNG if the slave stops
// making progress. DATA_BITS must be 32 or 64; TIMEOUT_CYCLES must be >= 2.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W valids up, each dropped after its own handshake
// WR_RESP | bready high, waiting for B
// RD_REQ  | arvalid high, waiting for arready
// RD_RESP | rready high, waiting for R
// RSP     | rsp_valid high until rsp_ready
// HUNG    | watchdog fired; one timeout response, then dead until reset
module perf_tcp_axil_cmd_master #(
    parameter int ADDR_BITS      = 64,
    parameter int DATA_BITS      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [DATA_BITS-1:0]   cmd_wdata,
    input  logic [DATA_BITS/8-1:0] cmd_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_wr,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout,
    output logic                   busy,
    perf_tcp_axil_cmd_master_if.master axi_ctrl
);
    localparam int WDOG_BITS = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter reaches zero on the last allowed cycle; the next edge times out.
    localparam logic [WDOG_BITS-1:0] WDOG_LOAD = WDOG_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, HUNG
    } state_t;

    state_t                 state, state_nxt;
    logic                   wr_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   wdata_q;
    logic [DATA_BITS/8-1:0] wstrb_q;
    logic                   awvalid_q, wvalid_q, arvalid_q;
    logic                   hung_pend;
    logic [WDOG_BITS-1:0]   wdog;
    logic                   bready_c, rready_c;
    logic                   aw_hs, w_hs, ar_hs, b_hs, r_hs, hs_any;
    logic                   waiting, timeout;

    // bready/rready stay up in HUNG so a late reply is swallowed, not left stuck.
    assign bready_c = (state == WR_RESP) || (state == HUNG && wr_q);
    assign rready_c = (state == RD_RESP) || (state == HUNG && !wr_q);

    assign aw_hs  = awvalid_q && axi_ctrl.awready;
    assign w_hs   = wvalid_q  && axi_ctrl.wready;
    assign ar_hs  = arvalid_q && axi_ctrl.arready;
    assign b_hs   = bready_c  && axi_ctrl.bvalid;
    assign r_hs   = rready_c  && axi_ctrl.rvalid;
    assign hs_any = aw_hs || w_hs || ar_hs || b_hs || r_hs;

    assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
    assign timeout = waiting && (wdog == '0) && !hs_any;

    assign axi_ctrl.awvalid = awvalid_q;
    assign axi_ctrl.awaddr  = addr_q;
    assign axi_ctrl.awprot  = 3'b000;
    assign axi_ctrl.wvalid  = wvalid_q;
    assign axi_ctrl.wdata   = wdata_q;
    assign axi_ctrl.wstrb   = wstrb_q;
    assign axi_ctrl.bready  = bready_c;
    assign axi_ctrl.arvalid = arvalid_q;
    assign axi_ctrl.araddr  = addr_q;
    assign axi_ctrl.arprot  = 3'b000;
    assign axi_ctrl.rready  = rready_c;
    assign rsp_wr           = wr_q;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and handshake-side outputs.
    always_comb begin
        state_nxt = state;
        // Gating with aresetn keeps cmd_ready low while reset is held.
        cmd_ready = (state == IDLE) && aresetn;
        busy      = (state != IDLE);
        rsp_valid = (state == RSP) || (state == HUNG && hung_pend);
        unique case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_wr ? WR_REQ : RD_REQ;
            WR_REQ: begin
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_nxt = WR_RESP;
                else if (timeout)                                  state_nxt = HUNG;
            end
            WR_RESP: begin
                if (b_hs)         state_nxt = RSP;
                else if (timeout) state_nxt = HUNG;
            end
            RD_REQ: begin
                if (ar_hs)        state_nxt = RD_RESP;
                else if (timeout) state_nxt = HUNG;
            end
            RD_RESP: begin
                if (r_hs)         state_nxt = RSP;
                else if (timeout) state_nxt = HUNG;
            end
            RSP:     if (rsp_ready) state_nxt = IDLE;
            HUNG:    state_nxt = HUNG;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, AXI valid tracking, watchdog and response registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            hung_pend   <= 1'b0;
            wdog        <= '0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                wr_q      <= cmd_wr;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                awvalid_q <= cmd_wr;
                wvalid_q  <= cmd_wr;
                arvalid_q <= !cmd_wr;
            end else begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs)  wvalid_q  <= 1'b0;
                if (ar_hs) arvalid_q <= 1'b0;
            end

            if (hs_any || state_nxt != state) wdog <= WDOG_LOAD;
            else if (waiting && wdog != '0)   wdog <= wdog - 1'b1;

            if (state == WR_RESP && b_hs) begin
                rsp_rdata   <= '0;
                rsp_resp    <= axi_ctrl.bresp;
                rsp_timeout <= 1'b0;
            end
            if (state == RD_RESP && r_hs) begin
                rsp_rdata   <= axi_ctrl.rdata;
                rsp_resp    <= axi_ctrl.rresp;
                rsp_timeout <= 1'b0;
            end

            if (timeout) begin
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
                hung_pend   <= 1'b1;
            end else if (state == HUNG && rsp_ready) begin
                hung_pend   <= 1'b0;
            end
        end
    end
endmodule
